// File: rtl/isa_pkg.sv
// ISA definitions for the 16-bit core: opcodes, per-op operand/write classes
// and the decode/issue FSM state type.
package isa_pkg;

  localparam int ISA_DW = 16;
  localparam int ISA_RW = 4;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_RED    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  typedef enum logic [1:0] {RUN, STALL, HALT} state_e;

  // uses_rt means "second read port carries a real operand", whichever field feeds it
  typedef struct packed {
    logic writes_rd;
    logic uses_rs;
    logic uses_rt;
    logic src2_is_rd;
    logic mem_rd;
    logic mem_wr;
  } op_class_t;

  // Shifts/rotates, LW and branches carry immediates in the rt field, so rt is unused there
  function automatic op_class_t op_class(input logic [3:0] op);
    op_class_t c;
    c = '0;
    case (op)
      OP_ADD, OP_PADDSB, OP_SUB, OP_XOR, OP_RED: begin
        c.writes_rd = 1'b1;
        c.uses_rs   = 1'b1;
        c.uses_rt   = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        c.writes_rd = 1'b1;
        c.uses_rs   = 1'b1;
      end
      OP_LW: begin
        c.writes_rd = 1'b1;
        c.uses_rs   = 1'b1;
        c.mem_rd    = 1'b1;
      end
      OP_SW: begin
        c.uses_rs    = 1'b1;
        c.uses_rt    = 1'b1;
        c.src2_is_rd = 1'b1;
        c.mem_wr     = 1'b1;
      end
      OP_LLB, OP_LHB: begin
        c.writes_rd  = 1'b1;
        c.uses_rt    = 1'b1;
        c.src2_is_rd = 1'b1;
      end
      OP_BR:  c.uses_rs   = 1'b1;
      OP_PCS: c.writes_rd = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_issue_stage_operand_bypass.sv
// Per-port operand select: R0 forces zero, a matching writeback overrides the
// register file read (the file itself has no internal bypass).
module operand_bypass
  import isa_pkg::*;
#(
  parameter int DW = ISA_DW,
  parameter int RW = ISA_RW
) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] rf_data,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] operand
);

  always_comb begin
    operand = rf_data;
    if (src == '0) begin
      operand = '0;
    end else if (wb_we && (wb_dst == src)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register selects, bypassed operand capture into ID/EX,
// load-use stall, flush squash and HLT handling.
module decode_issue_stage
  import isa_pkg::*;
#(
  parameter int DW = ISA_DW,
  parameter int RW = ISA_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_valid,
  input  logic [DW-1:0] if_instr,
  input  logic [DW-1:0] if_pc,
  output logic          if_ready,
  input  logic          flush,
  output logic [RW-1:0] rf_src1,
  output logic [RW-1:0] rf_src2,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic          idex_valid,
  output logic [3:0]    idex_op,
  output logic [RW-1:0] idex_dst,
  output logic          idex_we,
  output logic          idex_mem_rd,
  output logic          idex_mem_wr,
  output logic [RW-1:0] idex_src1,
  output logic [RW-1:0] idex_src2,
  output logic [DW-1:0] idex_a,
  output logic [DW-1:0] idex_b,
  output logic [DW-1:0] idex_pc,
  output logic [7:0]    idex_imm,
  output logic          halted
);

  typedef struct packed {
    logic          valid;
    logic [3:0]    op;
    logic [RW-1:0] dst;
    logic          we;
    logic          mem_rd;
    logic          mem_wr;
    logic [RW-1:0] src1;
    logic [RW-1:0] src2;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] pc;
    logic [7:0]    imm;
  } idex_t;

  localparam idex_t BUBBLE = '0;

  state_e        state_q, state_d;
  idex_t         idex_q, idex_d, issue;
  op_class_t     cls;
  logic [3:0]    op;
  logic [RW-1:0] rd, rs, rt;
  logic [DW-1:0] opnd_a, opnd_b;
  logic          hazard;

  assign op  = if_instr[15:12];
  assign rd  = if_instr[11:8];
  assign rs  = if_instr[7:4];
  assign rt  = if_instr[3:0];
  assign cls = op_class(op);

  assign rf_src1 = rs;
  assign rf_src2 = cls.src2_is_rd ? rd : rt;

  operand_bypass #(.DW(DW), .RW(RW)) u_bypass_a (
    .src     (rf_src1),
    .rf_data (rf_data1),
    .wb_we   (wb_we),
    .wb_dst  (wb_dst),
    .wb_data (wb_data),
    .operand (opnd_a)
  );

  operand_bypass #(.DW(DW), .RW(RW)) u_bypass_b (
    .src     (rf_src2),
    .rf_data (rf_data2),
    .wb_we   (wb_we),
    .wb_dst  (wb_dst),
    .wb_data (wb_data),
    .operand (opnd_b)
  );

  always_comb begin
    issue        = BUBBLE;
    issue.valid  = 1'b1;
    issue.op     = op;
    issue.dst    = rd;
    issue.we     = cls.writes_rd && (rd != '0);
    issue.mem_rd = cls.mem_rd;
    issue.mem_wr = cls.mem_wr;
    issue.src1   = rf_src1;
    issue.src2   = rf_src2;
    issue.a      = opnd_a;
    issue.b      = opnd_b;
    issue.pc     = if_pc;
    issue.imm    = if_instr[7:0];
  end

  // Only a valid LW in ID/EX can create a load-use; bubbles carry mem_rd=0
  assign hazard = idex_q.valid && idex_q.mem_rd && (idex_q.dst != '0) &&
                  ((cls.uses_rs && (rs == idex_q.dst)) ||
                   (cls.uses_rt && (rf_src2 == idex_q.dst)));

  always_comb begin
    state_d  = state_q;
    idex_d   = BUBBLE;
    if_ready = 1'b1;
    if (flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (if_valid && hazard) begin
            if_ready = 1'b0;
            state_d  = STALL;
          end else if (if_valid) begin
            idex_d = issue;
            if (op == OP_HLT) state_d = HALT;
          end
        end
        STALL: begin
          if (if_valid) idex_d = issue;
          state_d = RUN;
        end
        HALT:    if_ready = 1'b0;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      idex_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

  assign idex_valid  = idex_q.valid;
  assign idex_op     = idex_q.op;
  assign idex_dst    = idex_q.dst;
  assign idex_we     = idex_q.we;
  assign idex_mem_rd = idex_q.mem_rd;
  assign idex_mem_wr = idex_q.mem_wr;
  assign idex_src1   = idex_q.src1;
  assign idex_src2   = idex_q.src2;
  assign idex_a      = idex_q.a;
  assign idex_b      = idex_q.b;
  assign idex_pc     = idex_q.pc;
  assign idex_imm    = idex_q.imm;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: environment register file, behavioural
// pipeline model, directed scenarios and a randomized run.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_next = 1'b0;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = '0;
  logic [15:0] if_pc = '0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_dst = '0;
  logic [15:0] wb_data = '0;
  logic        if_ready;
  logic [3:0]  rf_src1, rf_src2;
  logic [15:0] rf_data1, rf_data2;
  logic        idex_valid, idex_we, idex_mem_rd, idex_mem_wr, halted;
  logic [3:0]  idex_op, idex_dst, idex_src1, idex_src2;
  logic [15:0] idex_a, idex_b, idex_pc;
  logic [7:0]  idex_imm;

  always #5 clk = ~clk;

  // Register file stand-in; R0 deliberately holds junk to prove the stage zeroes it
  logic [15:0] regs [16];
  assign rf_data1 = regs[rf_src1];
  assign rf_data2 = regs[rf_src2];
  always @(posedge clk) if (wb_we) regs[wb_dst] <= wb_data;

  decode_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .flush(flush), .rf_src1(rf_src1), .rf_src2(rf_src2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_we(wb_we), .wb_dst(wb_dst),
    .wb_data(wb_data), .idex_valid(idex_valid), .idex_op(idex_op), .idex_dst(idex_dst),
    .idex_we(idex_we), .idex_mem_rd(idex_mem_rd), .idex_mem_wr(idex_mem_wr),
    .idex_src1(idex_src1), .idex_src2(idex_src2), .idex_a(idex_a), .idex_b(idex_b),
    .idex_pc(idex_pc), .idex_imm(idex_imm), .halted(halted)
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  dst;
    logic        we;
    logic        mrd;
    logic        mwr;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] pc;
    logic [7:0]  imm;
  } ex_t;

  ex_t  m_ex = '0;
  int   m_mode = 0;      // 0 running, 1 stalled, 2 halted
  logic m_rdy = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_src2(input logic [15:0] ins);
    return (ins[15:12] inside {4'h9, 4'hA, 4'hB}) ? ins[11:8] : ins[3:0];
  endfunction
  function automatic logic m_uses1(input logic [3:0] op);
    return op inside {[4'h0:4'h9], 4'hD};
  endfunction
  function automatic logic m_uses2(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h9, 4'hA, 4'hB};
  endfunction
  function automatic logic m_writes(input logic [3:0] op);
    return (op <= 4'h8) || (op inside {4'hA, 4'hB, 4'hE});
  endfunction
  function automatic logic [15:0] m_opnd(input logic [3:0] idx);
    if (idx == 4'h0) return 16'h0000;
    if (wb_we && wb_dst == idx) return wb_data;
    return regs[idx];
  endfunction

  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic fl, input logic we, input logic [3:0] dst, input logic [15:0] d);
    logic [3:0] op, s2;
    logic       haz;
    ex_t        iss, nx;
    @(posedge clk);
    #1;
    rst_n = rst_next; if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
    wb_we = we; wb_dst = dst; wb_data = d;
    @(negedge clk);
    if (!rst_n) begin m_ex = '0; m_mode = 0; end
    op  = ins[15:12];
    s2  = m_src2(ins);
    haz = m_ex.valid && m_ex.op == 4'h8 && m_ex.dst != 4'h0 &&
          ((m_uses1(op) && ins[7:4] == m_ex.dst) || (m_uses2(op) && s2 == m_ex.dst));
    if (fl)               m_rdy = 1'b1;
    else if (m_mode == 2) m_rdy = 1'b0;
    else if (m_mode == 1) m_rdy = 1'b1;
    else                  m_rdy = !(v && haz);
    chk("if_ready", if_ready, m_rdy);
    chk("rf_src1", rf_src1, ins[7:4]);
    chk("rf_src2", rf_src2, s2);
    chk("halted", halted, m_mode == 2);
    chk("idex_valid", idex_valid, m_ex.valid);
    chk("idex_op", idex_op, m_ex.op);
    chk("idex_dst", idex_dst, m_ex.dst);
    chk("idex_we", idex_we, m_ex.we);
    chk("idex_mem_rd", idex_mem_rd, m_ex.mrd);
    chk("idex_mem_wr", idex_mem_wr, m_ex.mwr);
    chk("idex_src1", idex_src1, m_ex.s1);
    chk("idex_src2", idex_src2, m_ex.s2);
    chk("idex_a", idex_a, m_ex.a);
    chk("idex_b", idex_b, m_ex.b);
    chk("idex_pc", idex_pc, m_ex.pc);
    chk("idex_imm", idex_imm, m_ex.imm);
    iss.valid = 1'b1;
    iss.op    = op;
    iss.dst   = ins[11:8];
    iss.we    = m_writes(op) && ins[11:8] != 4'h0;
    iss.mrd   = (op == 4'h8);
    iss.mwr   = (op == 4'h9);
    iss.s1    = ins[7:4];
    iss.s2    = s2;
    iss.a     = m_opnd(ins[7:4]);
    iss.b     = m_opnd(s2);
    iss.pc    = pc;
    iss.imm   = ins[7:0];
    nx = '0;
    if (!rst_n)               m_mode = 0;
    else if (fl)              m_mode = 0;
    else if (m_mode == 2)     m_mode = 2;
    else if (m_mode == 1)     begin if (v) nx = iss; m_mode = 0; end
    else if (v && haz)        m_mode = 1;
    else if (v)               begin nx = iss; if (op == 4'hF) m_mode = 2; end
    m_ex = nx;
  endtask

  function automatic logic [3:0] rreg();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [15:0] pre [16];
    logic        hv;
    logic [15:0] hi, hp;
    pre[0] = 16'hDEAD; pre[1] = 16'h0005; pre[2] = 16'h0007; pre[3] = 16'h0030;
    for (int i = 4; i < 16; i++) pre[i] = 16'($urandom);

    // Reset with the register file loaded through the writeback port
    rst_next = 1'b0;
    for (int i = 0; i < 16; i++) step(0, 16'h0, 16'h0, 0, 1, 4'(i), pre[i]);
    chk("reset_valid", idex_valid, 1'b0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_a", idex_a, 16'h0);
    rst_next = 1'b1;
    step(0, 16'h0, 16'h0, 0, 0, 0, 0);

    // ADD R3,R1,R2
    step(1, 16'h0312, 16'h0010, 0, 0, 0, 0);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0);
    chk("add_valid", idex_valid, 1'b1);
    chk("add_a", idex_a, 16'h0005);
    chk("add_b", idex_b, 16'h0007);
    chk("add_dst", idex_dst, 4'h3);
    chk("add_we", idex_we, 1'b1);

    // SUB R4,R1,R1 with writeback to R1 in the same cycle
    step(1, 16'h2411, 16'h0012, 0, 1, 4'h1, 16'hBEEF);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0);
    chk("byp_a", idex_a, 16'hBEEF);
    chk("byp_b", idex_b, 16'hBEEF);

    // ADD R5,R0,R0 while writing R0
    step(1, 16'h0500, 16'h0014, 0, 1, 4'h0, 16'h1234);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0);
    chk("r0_a", idex_a, 16'h0000);
    chk("r0_b", idex_b, 16'h0000);

    // LW R2 then ADD R6,R2,R3: one held cycle, one bubble, then re-read operands
    step(1, 16'h8210, 16'h0016, 0, 0, 0, 0);
    step(1, 16'h0623, 16'h0018, 0, 0, 0, 0);
    chk("lu_ready_low", if_ready, 1'b0);
    step(1, 16'h0623, 16'h0018, 0, 1, 4'h2, 16'h0099);
    chk("lu_bubble", idex_valid, 1'b0);
    chk("lu_ready_high", if_ready, 1'b1);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0);
    chk("lu_issue_valid", idex_valid, 1'b1);
    chk("lu_issue_dst", idex_dst, 4'h6);
    chk("lu_issue_a", idex_a, 16'h0099);
    chk("lu_issue_b", idex_b, 16'h0030);

    // Flush while stalled, then XOR R7,R1,R1 issues normally
    step(1, 16'h8210, 16'h0020, 0, 0, 0, 0);
    step(1, 16'h0623, 16'h0022, 0, 0, 0, 0);
    step(1, 16'h0623, 16'h0022, 1, 0, 0, 0);
    step(1, 16'h3711, 16'h0030, 0, 0, 0, 0);
    chk("fl_bubble", idex_valid, 1'b0);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0);
    chk("fl_next_valid", idex_valid, 1'b1);
    chk("fl_next_op", idex_op, 4'h3);
    chk("fl_next_dst", idex_dst, 4'h7);

    // HLT: halted and fetch held for 10 cycles, then flush releases
    step(1, 16'hF000, 16'h0040, 0, 0, 0, 0);
    chk("hlt_accept", if_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1, 16'hF000, 16'h0040, 0, 0, 0, 0);
      chk("hlt_halted", halted, 1'b1);
      chk("hlt_ready", if_ready, 1'b0);
      if (i == 0) chk("hlt_op", idex_op, 4'hF);
    end
    step(1, 16'hF000, 16'h0040, 1, 0, 0, 0);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0);
    chk("hlt_release_halted", halted, 1'b0);
    chk("hlt_release_ready", if_ready, 1'b1);

    // Randomized traffic; fetch holds its slot whenever the stage is not ready
    hv = 1'b0; hi = '0; hp = '0;
    for (int c = 0; c < 4000; c++) begin
      logic fl;
      rst_next = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      fl = ($urandom_range(0, 9) == 0);
      if (m_rdy || flush) begin
        hv = ($urandom_range(0, 4) != 0);
        hi = {4'($urandom_range(0, 15)), rreg(), rreg(), rreg()};
        hp = 16'($urandom);
      end
      step(hv, hi, hp, fl, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
